// File: rtl/x25519_pkg.sv
// Shared constants, widths and state encoding for the X25519/Ed25519 point path.
package x25519_pkg;

   localparam int FE_W      = 255;
   localparam int ENC_BYTES = 32;
   localparam int ENC_W     = 8 * ENC_BYTES;
   localparam int CNT_W     = $clog2(ENC_BYTES);

   localparam logic [FE_W-1:0] P25519 =
      255'd57896044618658097711785492504343953926634992332820282019728792003956564819949;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CAPTURE = 3'd1,
      REDUCE  = 3'd2,
      SEND    = 3'd3,
      DONE    = 3'd4
   } state_t;

endpackage

// File: rtl/canon_reduce.sv
// Single compare-and-conditional-subtract bringing a value below 2^W into [0, P).
module canon_reduce
   import x25519_pkg::*;
#(
   parameter int              W = FE_W,
   parameter logic [W-1:0]    P = P25519
)(
   input  logic [W-1:0] a,
   output logic [W-1:0] r
);

   logic [W:0] diff;

   // A borrow out of the top bit means a < P, so the input is already canonical.
   always_comb begin
      diff = {1'b0, a} - {1'b0, P};
      r    = diff[W] ? a : diff[W-1:0];
   end

endmodule

// File: rtl/point_encode_tx.sv
// Captures an affine point, canonicalises it mod p and streams its 32-byte encoding.
module point_encode_tx
   import x25519_pkg::*;
#(
   parameter logic [FE_W-1:0] P = P25519
)(
   input  logic            refclk,
   input  logic            rstn,
   input  logic [FE_W-1:0] px,
   input  logic [FE_W-1:0] py,
   input  logic            res_valid,
   output logic            res_ready,
   output logic [7:0]      tx_data,
   output logic            tx_valid,
   input  logic            tx_ready,
   output logic            tx_last,
   output logic            busy
);

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(ENC_BYTES - 1);

   state_t            state;
   state_t            state_nx;
   logic [FE_W-1:0]   x_q;
   logic [FE_W-1:0]   y_q;
   logic [FE_W-1:0]   xr;
   logic [FE_W-1:0]   yr;
   logic [ENC_W-1:0]  sr;
   logic [CNT_W-1:0]  cnt;
   logic              capture;
   logic              accept;

   canon_reduce #(.W(FE_W), .P(P)) u_reduce_x (.a(x_q), .r(xr));
   canon_reduce #(.W(FE_W), .P(P)) u_reduce_y (.a(y_q), .r(yr));

   // Requiring res_ready low guarantees a held res_valid is never captured twice.
   assign capture = (state == IDLE) && res_valid && !res_ready;
   assign accept  = tx_valid && tx_ready;

   always_ff @(posedge refclk) begin
      if (!rstn) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (capture) state_nx = CAPTURE;
         CAPTURE: state_nx = REDUCE;
         REDUCE:  state_nx = SEND;
         SEND:    if (accept && (cnt == LAST_IDX)) state_nx = DONE;
         DONE:    if (!res_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge refclk) begin
      if (!rstn) begin
         res_ready <= 1'b0;
         tx_valid  <= 1'b0;
         sr        <= '0;
         cnt       <= '0;
         x_q       <= '0;
         y_q       <= '0;
      end else begin
         if (capture)                     res_ready <= 1'b1;
         else if (!res_valid && res_ready) res_ready <= 1'b0;

         case (state)
            IDLE: begin
               if (capture) begin
                  x_q <= px;
                  y_q <= py;
               end
            end
            // Reduced values overwrite the raw coordinates; the carry chain ends here.
            CAPTURE: begin
               x_q <= xr;
               y_q <= yr;
            end
            REDUCE: begin
               sr       <= {x_q[0], y_q};
               cnt      <= '0;
               tx_valid <= 1'b1;
            end
            SEND: begin
               if (accept) begin
                  sr <= sr >> 8;
                  if (cnt == LAST_IDX) begin
                     cnt      <= '0;
                     tx_valid <= 1'b0;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign tx_data = sr[7:0];
   assign tx_last = (state == SEND) && (cnt == LAST_IDX);
   assign busy    = (state != IDLE);

endmodule

// File: doc/point_encode_tx.md
# point_encode_tx

Downstream stage of `scalarmultB`: accepts the affine result point (px, py) through the four-phase `res_valid`/`res_ready` handshake, reduces both coordinates to canonical form mod p = 2^255−19, and forms the 32-byte Ed25519 point encoding. The encoding is y little-endian, with bit 255 set to the parity of x. The 32 bytes are streamed out on a valid/ready byte interface toward a UART/host transmitter, replacing the on-chip compare-and-count check.

## Interface
- `P`, default 255'd57896044618658097711785492504343953926634992332820282019728792003956564819949, field modulus used for canonical reduction.
- `refclk` input 1: clock; all logic on posedge.
- `rstn` input 1: reset, synchronous, active-low; clock refclk.
- `px` input 255: affine x from upstream; sampled only at capture.
- `py` input 255: affine y from upstream; sampled only at capture.
- `res_valid` input 1: upstream result valid; held until acknowledged.
- `res_ready` output 1: acknowledge to upstream (four-phase).
- `tx_data` output 8: encoded byte.
- `tx_valid` output 1: `tx_data` valid.
- `tx_ready` input 1: sink accepts the byte when `tx_valid & tx_ready`.
- `tx_last` output 1: high with byte 31.
- `busy` output 1: high in any state other than IDLE.

## Operation
- Reset values (`rstn`=0 at edge): state IDLE, `res_ready`=0, `tx_valid`=0, `tx_last`=0, `tx_data`=0, `busy`=0, byte counter=0.
- IDLE → CAPTURE, when `res_valid & !res_ready`:
  - Register px and py.
  - Set `res_ready`=1.
- CAPTURE → REDUCE (one cycle) computes:
  - xr = (x ≥ P) ? x−P : x
  - yr = (y ≥ P) ? y−P : y
  - Both values fit in 255 bits. Inputs are at most 2^255−1, so a single subtraction is sufficient.
- REDUCE → SEND:
  - Load the 256-bit shift register with {xr[0], yr}.
  - Clear the counter.
  - Set `tx_valid`=1, `tx_data`=sr[7:0].
- SEND:
  - On `tx_valid & tx_ready`: shift sr right by 8, increment the counter, present the next byte in the following cycle with no bubble.
  - `tx_last`=1 exactly while counter=31.
  - Acceptance of byte 31 → DONE, with `tx_valid`=0.
- DONE → IDLE when `res_ready`=0.
- `res_ready` release rule, independent of state: clear `res_ready` on the first edge where `res_valid`=0 and `res_ready`=1.
  - A new capture requires both IDLE and `res_ready`=0. Upstream may therefore drop `res_valid` early, and no result is ever captured twice.
- `tx_valid` never deasserts and `tx_data` never changes without a handshake, except on reset.
- Reset mid-stream aborts the transfer immediately: partial frame, no `tx_last`.

## Timing
- Edge e0 samples `res_valid`=1 (IDLE). The resulting sequence is:
  - After e0: `res_ready`=1, state CAPTURE.
  - After e1: REDUCE.
  - After e2: `tx_valid`=1 with byte 0.
- Minimum frame is 32 cycles with `tx_ready` held at 1. First-valid-to-last-accept is 34 edges from the capture edge.
- Throughput: one byte per cycle under continuous `tx_ready`. A new point can be captured no earlier than one cycle after DONE.
- Counter is 5-bit. Wrap from 31 to 0 happens only on the DONE transition.

## Structure
- Shared package `x25519_pkg`:
  - constant P25519
  - widths FE_W=255, ENC_BYTES=32
  - state encoding IDLE/CAPTURE/REDUCE/SEND/DONE
- Sub-module `canon_reduce`: combinational 255-bit compare-and-conditional-subtract, instantiated twice (x and y).
  - Registered at the REDUCE boundary; this is the only long carry path.
- Top FSM, counter, shift register and handshake logic live in `point_encode_tx`.

## Test plan
- px=1, py=1, `tx_ready`=1:
  - Bytes are 0x01, then 0x00 ×30, then 0x80.
  - `tx_last` only on byte 31.
  - `res_ready` rises the cycle after capture.
- px=P+1, py=P (non-canonical inputs):
  - Bytes 0–30 are 0x00, byte 31 is 0x80.
  - This proves both reductions and that the sign is taken from xr.
- Upstream result from `scalarmultB` (x=1735…9906, y=2973…8128):
  - byte 0 = 0x70.
  - byte 31 bit 7 = 0 (x is even).
  - Reassembled bytes equal y.
- `tx_ready` random 30% duty:
  - Each byte is held stable until accepted.
  - Exactly 32 handshakes.
  - No duplicated or skipped bytes.
- Four-phase handshake:
  - `res_valid` held high for 100 cycles after frame end → no second capture, `res_ready` stays 1.
  - Then drop `res_valid` → `res_ready` clears next edge.
  - Re-raise → a second frame is produced.
- `rstn` low for one edge after byte 10 → next cycle all outputs 0 and state IDLE. A fresh `res_valid` then yields a complete 32-byte frame.
